// File: rtl/logic_operand_collector_if.sv
// Operand collector bus: bit-serial source and gate mux handshakes.
// The master side drives requests and the slave side returns frame state.
interface logic_operand_collector_if;
    logic       start;
    logic [3:0] gate_sel;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_last;
    logic       abort;
    logic       result_ack;
    logic [3:0] gate_type;
    logic       op1;
    logic       op2;
    logic       op3;
    logic       op4;
    logic [1:0] no_of_inp;
    logic       op_ack_in_pulse;
    logic       final_inp_ack;
    logic       busy;
    logic       ovf_err;
    logic       tmo_err;

    modport master (
        output start, gate_sel, bit_in, bit_valid,
        output bit_last, abort, result_ack,
        input  gate_type, op1, op2, op3, op4, no_of_inp,
        input  op_ack_in_pulse, final_inp_ack, busy,
        input  ovf_err, tmo_err
    );

    modport slave (
        input  start, gate_sel, bit_in, bit_valid,
        input  bit_last, abort, result_ack,
        output gate_type, op1, op2, op3, op4, no_of_inp,
        output op_ack_in_pulse, final_inp_ack, busy,
        output ovf_err, tmo_err
    );
endinterface

// File: rtl/logic_operand_collector.sv
// Serial operand front-end for the logic-gate mux.
// Optional inter-bit timeout is built when OPERAND_TIMEOUT_EN is defined.
module logic_operand_collector #(
    parameter int unsigned TMO_CYCLES = 12
) (
    input logic clk,
    input logic reset,
    logic_operand_collector_if.slave bus
);

    if (TMO_CYCLES < 1 || TMO_CYCLES > 15) begin : g_bad_tmo
        $error("TMO_CYCLES must be 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] idx;
    logic [3:0] gate_q;
    logic [3:0] ops;
    logic [1:0] nin;
    logic       pulse;
    logic       fin;
    logic       ovf;

`ifdef OPERAND_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(TMO_CYCLES - 1);
    logic [3:0] cnt;
    logic       tmo;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            gate_q <= '0;
            ops    <= '0;
            nin    <= '0;
            pulse  <= 1'b0;
            fin    <= 1'b0;
            ovf    <= 1'b0;
`ifdef OPERAND_TIMEOUT_EN
            cnt    <= '0;
            tmo    <= 1'b0;
`endif
        end else begin
            pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!bus.abort && bus.start) begin
                        gate_q <= bus.gate_sel;
                        ops    <= '0;
                        idx    <= '0;
`ifdef OPERAND_TIMEOUT_EN
                        cnt    <= '0;
`endif
                        state  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.abort) begin
                        fin   <= 1'b0;
                        state <= IDLE;
                    end else if (bus.bit_valid) begin
                        // a fifth bit is dropped without a pulse
                        if (idx[2]) begin
                            ovf   <= 1'b1;
                            state <= ERR;
                        end else begin
                            ops[idx[1:0]] <= bus.bit_in;
                            idx   <= idx + 3'd1;
                            pulse <= 1'b1;
`ifdef OPERAND_TIMEOUT_EN
                            cnt   <= '0;
`endif
                            if (bus.bit_last) begin
                                nin   <= idx[1:0];
                                fin   <= 1'b1;
                                state <= HOLD;
                            end
                        end
                    end
`ifdef OPERAND_TIMEOUT_EN
                    else if (cnt == TMO_LAST) begin
                        tmo   <= 1'b1;
                        state <= ERR;
                    end else if (cnt != 4'hf) begin
                        cnt <= cnt + 4'd1;
                    end
`endif
                end
                HOLD: begin
                    if (bus.abort || bus.result_ack) begin
                        fin   <= 1'b0;
                        state <= IDLE;
                    end
                end
                ERR: begin
                    if (bus.abort) begin
                        ovf   <= 1'b0;
`ifdef OPERAND_TIMEOUT_EN
                        tmo   <= 1'b0;
`endif
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.gate_type       = gate_q;
    assign bus.op1             = ops[0];
    assign bus.op2             = ops[1];
    assign bus.op3             = ops[2];
    assign bus.op4             = ops[3];
    assign bus.no_of_inp       = nin;
    assign bus.op_ack_in_pulse = pulse;
    assign bus.final_inp_ack   = fin;
    assign bus.busy            = (state != IDLE);
    assign bus.ovf_err         = ovf;
`ifdef OPERAND_TIMEOUT_EN
    assign bus.tmo_err         = tmo;
`else
    assign bus.tmo_err         = 1'b0;
`endif

endmodule

// File: tb/tb_logic_operand_collector.sv
// Scoreboard bench for logic_operand_collector: frame-level model feeds
// an expectation queue drained by a negedge monitor.
module tb_logic_operand_collector;

    localparam int TMO = 12;
`ifdef OPERAND_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic_operand_collector_if bus();

    logic_operand_collector #(.TMO_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {K_DONE, K_OVF, K_TMO, K_OPEN} kind_e;
    typedef struct {
        kind_e      kind;
        logic [3:0] gate;
        logic [3:0] ops;
        logic [1:0] nin;
        int         pulses;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int fg[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 'h%0h want 'h%0h", name, act, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] all_out();
        return {bus.gate_type, bus.op4, bus.op3, bus.op2, bus.op1,
                bus.no_of_inp, bus.op_ack_in_pulse, bus.final_inp_ack,
                bus.busy, bus.ovf_err, bus.tmo_err};
    endfunction

    // Reference model: outcome of a frame from its bit list and gaps.
    function automatic exp_t model(input logic [3:0] g, input int n,
                                   input logic [4:0] vals,
                                   input int last_at);
        exp_t e;
        int acc;
        e.kind = K_OPEN;
        e.gate = g;
        e.ops = '0;
        e.nin = '0;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            if (TMO_EN && fg[i] >= TMO) begin
                e.kind = K_TMO;
                break;
            end
            if (acc == 4) begin
                e.kind = K_OVF;
                break;
            end
            e.ops[acc] = vals[i];
            acc++;
            if (i == last_at) begin
                e.kind = K_DONE;
                e.nin = 2'(acc - 1);
                break;
            end
        end
        e.pulses = acc;
        return e;
    endfunction

    task automatic frame(input logic [3:0] g, input int n,
                         input logic [4:0] vals, input int last_at,
                         input int hold, input bit end_abort);
        exp_t e;
        e = model(g, n, vals, last_at);
        if (e.kind != K_OPEN) q.push_back(e);
        bus.start = 1'b1;
        bus.gate_sel = g;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (fg[i]) cycle();
            if (TMO_EN && fg[i] >= TMO) break;
            bus.bit_valid = 1'b1;
            bus.bit_in = vals[i];
            bus.bit_last = (i == last_at);
            cycle();
            bus.bit_valid = 1'b0;
            bus.bit_last = 1'b0;
            if (i == last_at || i == 4) break;
        end
        if (e.kind == K_DONE) begin
            repeat (hold) cycle();
            if (end_abort) bus.abort = 1'b1;
            else bus.result_ack = 1'b1;
            cycle();
            bus.abort = 1'b0;
            bus.result_ack = 1'b0;
            chk("fin_drop", 32'(bus.final_inp_ack), 0);
            chk("idle_after", 32'(bus.busy), 0);
        end else begin
            bus.abort = 1'b1;
            cycle();
            bus.abort = 1'b0;
            chk("err_clear", {bus.ovf_err, bus.tmo_err, bus.busy}, 0);
        end
    endtask

    // Monitor
    exp_t m_e;
    exp_t m_cur;
    int   m_pulses = 0;
    int   m_cyc = 0;
    int   m_ref = 0;
    logic m_pfin = 1'b0;
    logic m_povf = 1'b0;
    logic m_ptmo = 1'b0;
    logic m_pbusy = 1'b0;

    always @(negedge clk) begin
        m_cyc++;
        if (!bus.busy) m_pulses = 0;
        if (bus.busy && !m_pbusy) m_ref = m_cyc;
        if (bus.op_ack_in_pulse) begin
            m_pulses++;
            m_ref = m_cyc;
        end
        if (bus.final_inp_ack && !m_pfin) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_final: got final, want none");
            end else begin
                m_e = q.pop_front();
                chk("done_kind", 32'(m_e.kind), 32'(K_DONE));
                chk("done_gate", 32'(bus.gate_type), 32'(m_e.gate));
                chk("done_ops",
                    {bus.op4, bus.op3, bus.op2, bus.op1}, 32'(m_e.ops));
                chk("done_nin", 32'(bus.no_of_inp), 32'(m_e.nin));
                chk("done_pulses", m_pulses, m_e.pulses);
                m_cur = m_e;
            end
        end else if (bus.final_inp_ack) begin
            chk("hold_stable",
                {bus.gate_type, bus.op4, bus.op3, bus.op2, bus.op1,
                 bus.no_of_inp},
                {m_cur.gate, m_cur.ops, m_cur.nin});
        end
        if (bus.ovf_err && !m_povf) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ovf: got ovf, want none");
            end else begin
                m_e = q.pop_front();
                chk("ovf_kind", 32'(m_e.kind), 32'(K_OVF));
                chk("ovf_pulses", m_pulses, m_e.pulses);
                chk("ovf_fin", 32'(bus.final_inp_ack), 0);
                chk("ovf_ops",
                    {bus.op4, bus.op3, bus.op2, bus.op1}, 32'(m_e.ops));
            end
        end
`ifdef OPERAND_TIMEOUT_EN
        if (bus.tmo_err && !m_ptmo) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tmo: got tmo, want none");
            end else begin
                m_e = q.pop_front();
                chk("tmo_kind", 32'(m_e.kind), 32'(K_TMO));
                chk("tmo_pulses", m_pulses, m_e.pulses);
                chk("tmo_delay", m_cyc - m_ref, TMO);
            end
        end
`endif
        m_pfin = bus.final_inp_ack;
        m_povf = bus.ovf_err;
        m_ptmo = bus.tmo_err;
        m_pbusy = bus.busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last_at;
        int r;
        bus.start = 0;
        bus.gate_sel = 0;
        bus.bit_in = 0;
        bus.bit_valid = 0;
        bus.bit_last = 0;
        bus.abort = 0;
        bus.result_ack = 0;
        reset = 1'b1;
        #1;
        chk("reset_state", 32'(all_out()), 0);
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        chk("idle_state", 32'(all_out()), 0);

        // start and abort together: abort wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.gate_sel = 4'h5;
        cycle();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort", 32'(bus.busy), 0);

        // bit_valid in IDLE is ignored
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        cycle();
        bus.bit_valid = 1'b0;
        chk("idle_bit", 32'(all_out()), 0);

        fg = '{0, 0, 0, 0, 0};
        frame(4'b0010, 2, 5'b00011, 1, 2, 1'b0);
        frame(4'h7, 4, 5'b01101, 3, 1, 1'b0);
        frame(4'h3, 5, 5'b10101, -1, 0, 1'b0);
        frame(4'h9, 1, 5'b00000, 0, 0, 1'b0);
        frame(4'hc, 2, 5'b00010, 1, 1, 1'b1);

        // reset mid-collect
        bus.start = 1'b1;
        bus.gate_sel = 4'hb;
        cycle();
        bus.start = 1'b0;
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        cycle();
        bus.bit_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_reset", 32'(all_out()), 0);
        #1;
        reset = 1'b0;
        cycle();
        frame(4'h6, 3, 5'b00101, 2, 0, 1'b0);

`ifdef OPERAND_TIMEOUT_EN
        fg = '{0, 12, 0, 0, 0};
        frame(4'h1, 2, 5'b00011, 1, 0, 1'b0);
        fg = '{0, 11, 0, 0, 0};
        frame(4'h2, 2, 5'b00011, 1, 0, 1'b0);
        fg = '{12, 0, 0, 0, 0};
        frame(4'h4, 2, 5'b00011, 1, 0, 1'b0);
`endif

        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(1, 5);
            r = $urandom_range(0, 9);
            if (r < 7) last_at = n - 1;
            else if (r < 8) last_at = -1;
            else last_at = $urandom_range(0, n - 1);
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 9) == 0)
                    fg[i] = $urandom_range(10, 13);
                else
                    fg[i] = $urandom_range(0, 2);
            end
            frame(4'($urandom), n, 5'($urandom), last_at,
                  $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        repeat (3) cycle();
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_operand_collector.md
# logic_operand_collector

Serial operand front-end for the logic-gate mux. Accepts operand bits one per beat from a bit-serial source, latches them into four operand slots, and captures the gate selection. It drives the mux's operand, count, per-input acknowledge and final-acknowledge inputs, then holds the frame stable until the mux returns its output acknowledge. It sits directly upstream of the gate mux and shares its clock and reset.

## Interface
- `TMO_CYCLES`, default 12: maximum idle cycles allowed between accepted bits while collecting; must be 1..15 and below the mux's 16-cycle limit.
- `clk` in 1: single synchronous clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new frame; sampled only in IDLE.
- `gate_sel` in 4: gate code, captured on the `start` cycle and passed through unchanged.
- `bit_in` in 1: operand bit value.
- `bit_valid` in 1: `bit_in` is valid this cycle.
- `bit_last` in 1: this beat is the final operand; qualified by `bit_valid`.
- `abort` in 1: drop the current frame and return to IDLE.
- `result_ack` in 1: the mux's output acknowledge; closes the frame.
- `gate_type` out 4: captured gate code. Reset value 0.
- `op1`..`op4` out 1 each: operand slots. Reset value 0.
- `no_of_inp` out 2: accepted operand count minus 1. Reset value 0.
- `op_ack_in_pulse` out 1: one-cycle pulse per accepted bit. Reset value 0.
- `final_inp_ack` out 1: frame complete, held until closed. Reset value 0.
- `busy` out 1: high in any state except IDLE. Reset value 0.
- `ovf_err` out 1: sticky error, more than 4 bits received. Reset value 0.
- `tmo_err` out 1: sticky error, inter-bit timeout. Reset value 0.

## Operation
- **States:** IDLE, COLLECT, HOLD, ERR. Encoding is 2 bits.
- **IDLE:**
  - On `start`: capture `gate_sel`, clear `op1`..`op4`, clear the slot index, go to COLLECT.
  - `bit_valid` is ignored in IDLE.
- **COLLECT:**
  - Each `bit_valid` writes `bit_in` to the slot at the index (0 to `op1` … 3 to `op4`), then increments the index.
  - `op_ack_in_pulse` is registered: high for one cycle after each accepted bit.
  - `bit_valid` with `bit_last` and index ≤ 3: go to HOLD, set `no_of_inp` = index (pre-increment value), set `final_inp_ack` = 1.
  - `bit_valid` with index = 4 (a fifth bit): the bit is discarded, no pulse is generated, set `ovf_err`, go to ERR. This applies whether or not `bit_last` is set.
- **HOLD:**
  - All outputs are frozen and `bit_valid` is ignored.
  - On `result_ack`: clear `final_inp_ack`, go to IDLE.
- **ERR:** `final_inp_ack` stays 0. `abort` clears `ovf_err` and `tmo_err` and goes to IDLE.
- **abort:**
  - In COLLECT or HOLD: go to IDLE and clear `final_inp_ack`.
  - `abort` has priority over `bit_valid`, `result_ack` and the timeout.
- **Idle counter:**
  - 4-bit counter, running only in COLLECT.
  - Cleared on entry to COLLECT and on every accepted bit.
  - Saturates; it never wraps.
- **Simultaneous `start` and `abort` in IDLE:** `abort` wins and the block stays in IDLE.

## Timing
- Bit accepted at edge N: the slot and `op_ack_in_pulse` are valid after edge N.
- Final bit at edge N: `final_inp_ack`, `no_of_inp` and the last slot all become valid after edge N, in the same cycle.
- Two back-to-back `bit_valid` beats give two pulses on consecutive cycles, with no gap required.
- The mux can therefore sample the operands in the first cycle that `final_inp_ack` is high.
- `result_ack` to IDLE takes one cycle, and `start` may be asserted in the following cycle.
- Reset mid-frame: all outputs go to their reset values immediately (asynchronous), and the state is IDLE.

## Configuration
- **Macro `OPERAND_TIMEOUT_EN`, defined:**
  - The idle counter is built.
  - When the count reaches `TMO_CYCLES` in COLLECT, the block sets `tmo_err` and goes to ERR.
  - If a `bit_valid` arrives in that same cycle, the bit is accepted and the timeout does not fire.
- **Macro `OPERAND_TIMEOUT_EN`, undefined:**
  - No counter is built.
  - `tmo_err` is tied to 0.
  - COLLECT waits indefinitely; the upstream logic is then responsible for pacing.

## Test plan
- **Two operands:** `start` with `gate_sel`=4'b0010, then bits 1 and 1 (`bit_last` on the second) -> two pulses, `op1`=`op2`=1, `no_of_inp`=2'b01, `final_inp_ack`=1 until `result_ack`, then IDLE with `busy`=0.
- **Four operands:** bits 1,0,1,1 with `bit_last` on the fourth -> `op1`..`op4`=1,0,1,1, `no_of_inp`=2'b11, four pulses on consecutive cycles.
- **Overflow:** five bits without `bit_last` -> `ovf_err`=1 after the fifth edge, only 4 pulses, `final_inp_ack`=0; `abort` -> `ovf_err`=0, IDLE.
- **Timeout (`OPERAND_TIMEOUT_EN` defined, `TMO_CYCLES`=12):** one bit, then silence -> `tmo_err`=1 exactly 12 cycles after the last accepted bit, ERR. A bit on cycle 12 -> no error.
- **Abort / reset:** `abort` in HOLD -> `final_inp_ack` drops next cycle, IDLE. `reset` asserted mid-COLLECT -> all outputs 0 asynchronously; a subsequent frame completes normally.
- **Single operand:** one bit = 0 with `bit_last` -> `no_of_inp`=2'b00, `op1`=0, one pulse, `final_inp_ack`=1.
